imem_program_loader: RTL and testbench

- Writer side of the instruction-memory fetch interface. Receives a program image over a byte-wide valid/ready stream and writes it as 32-bit words into instruction memory at incrementing word addresses.
- Holds the processor core in reset while loading. Releases it only after a complete image with a correct checksum has been written.
- Sits between the host/UART byte source and the instruction memory write port. Drives the core's reset input.

---
 rtl/imem_program_loader.sv | 145 ++++++++++++++
 tb/tb_imem_program_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_program_loader.sv
// Streams a framed program image into instruction memory as 32-bit words and
// holds the core in reset until the whole image has passed its XOR checksum.
module imem_program_loader #(
  parameter int          ADDR_W    = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE, SYNC, CNT_H, CNT_L, LOAD, CSUM, DONE, ERR
  } state_t;

  localparam logic [16:0] MaxWords = 17'd1 << ADDR_W;

  state_t              state_q, state_d;
  logic [7:0]          cntHigh_q, cntHigh_d;
  logic [15:0]         wordCount_q, wordCount_d;
  logic [ADDR_W:0]     wordIdx_q, wordIdx_d;
  logic [1:0]          byteIdx_q, byteIdx_d;
  logic [23:0]         shift_q, shift_d;
  logic [7:0]          csum_q, csum_d;
  logic                imemWe_q, imemWe_d;
  logic [ADDR_W-1:0]   imemAddr_q, imemAddr_d;
  logic [31:0]         imemWdata_q, imemWdata_d;

  logic                accept;
  logic [16:0]         countIn;
  logic                lastWord;

  assign accept   = s_valid && s_ready;
  assign countIn  = {1'b0, cntHigh_q, s_data};
  // wordIdx_q is one bit wider than the address so a full-depth image can be counted.
  assign lastWord = (({{(16-ADDR_W){1'b0}}, wordIdx_q} + 17'd1) == {1'b0, wordCount_q});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cntHigh_q   <= '0;
      wordCount_q <= '0;
      wordIdx_q   <= '0;
      byteIdx_q   <= '0;
      shift_q     <= '0;
      csum_q      <= '0;
      imemWe_q    <= 1'b0;
      imemAddr_q  <= '0;
      imemWdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cntHigh_q   <= cntHigh_d;
      wordCount_q <= wordCount_d;
      wordIdx_q   <= wordIdx_d;
      byteIdx_q   <= byteIdx_d;
      shift_q     <= shift_d;
      csum_q      <= csum_d;
      imemWe_q    <= imemWe_d;
      imemAddr_q  <= imemAddr_d;
      imemWdata_q <= imemWdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cntHigh_d   = cntHigh_q;
    wordCount_d = wordCount_q;
    wordIdx_d   = wordIdx_q;
    byteIdx_d   = byteIdx_q;
    shift_d     = shift_q;
    csum_d      = csum_q;
    imemWe_d    = 1'b0;
    imemAddr_d  = imemAddr_q;
    imemWdata_d = imemWdata_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d   = SYNC;
          wordIdx_d = '0;
          byteIdx_d = '0;
          csum_d    = '0;
        end
      end
      SYNC: begin
        if (accept && (s_data == SYNC_BYTE)) state_d = CNT_H;
      end
      CNT_H: begin
        if (accept) begin
          cntHigh_d = s_data;
          state_d   = CNT_L;
        end
      end
      CNT_L: begin
        if (accept) begin
          wordCount_d = countIn[15:0];
          if (countIn == 17'd0)        state_d = CSUM;
          else if (countIn > MaxWords) state_d = ERR;
          else                         state_d = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          csum_d = csum_q ^ s_data;
          if (byteIdx_q == 2'd3) begin
            imemWe_d    = 1'b1;
            imemAddr_d  = wordIdx_q[ADDR_W-1:0];
            imemWdata_d = {shift_q, s_data};
            wordIdx_d   = wordIdx_q + {{ADDR_W{1'b0}}, 1'b1};
            byteIdx_d   = 2'd0;
            if (lastWord) state_d = CSUM;
          end else begin
            shift_d   = {shift_q[15:0], s_data};
            byteIdx_d = byteIdx_q + 2'd1;
          end
        end
      end
      CSUM: begin
        if (accept) state_d = (s_data == csum_q) ? DONE : ERR;
      end
      default: state_d = IDLE;
    endcase
  end

  assign s_ready    = (state_q == SYNC) || (state_q == CNT_H) || (state_q == CNT_L) ||
                      (state_q == LOAD) || (state_q == CSUM);
  assign busy       = s_ready;
  assign done       = (state_q == DONE);
  assign err        = (state_q == ERR);
  assign cpu_rst    = (state_q != DONE);
  assign imem_we    = imemWe_q;
  assign imem_addr  = imemAddr_q;
  assign imem_wdata = imemWdata_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed self-checking bench for imem_program_loader; a negedge monitor
// records every memory write so results can be compared with hand-computed words.
module tb_imem_program_loader;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  sData;
   logic        sValid;
   logic        sReady;
   logic        imemWe;
   logic [7:0]  imemAddr;
   logic [31:0] imemWdata;
   logic        cpuRst;
   logic        busy;
   logic        done;
   logic        err;

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;

   int          wrCount = 0;
   logic [7:0]  wrAddr [0:511];
   logic [31:0] wrData [0:511];
   logic [7:0]  payload [0:1023];
   logic [7:0]  csumModel;

   imem_program_loader #(.ADDR_W(8), .SYNC_BYTE(8'hA5)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .s_data     (sData),
      .s_valid    (sValid),
      .s_ready    (sReady),
      .imem_we    (imemWe),
      .imem_addr  (imemAddr),
      .imem_wdata (imemWdata),
      .cpu_rst    (cpuRst),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Capture each write strobe away from the active edge.
   always @(negedge clk) begin
      if (imemWe && wrCount < 512) begin
         wrAddr[wrCount] = imemAddr;
         wrData[wrCount] = imemWdata;
         wrCount++;
      end
   end

   // Hard stop in case a wait is never satisfied.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Compares one observed value with its expected value and keeps the tallies.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Offers one byte after an optional idle gap and returns #1 after it is accepted.
   task automatic applyStimulus(input logic [7:0] b, input int gap);
      int waitCycles;
      sValid = 1'b0;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      sData  = b;
      sValid = 1'b1;
      waitCycles = 0;
      while (!sReady && waitCycles < 20) begin
         @(negedge clk);
         waitCycles++;
      end
      if (!sReady) begin
         checkOutput("readyTimeout", {31'd0, sReady}, 32'd1);
         sValid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         sValid = 1'b0;
      end
   endtask

   // Single-cycle start pulse launched from a falling edge.
   task automatic pulseStart();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Sends the two-word reference frame with the given checksum byte.
   task automatic sendRefFrame(input logic [7:0] csumByte);
      logic [7:0] frame [0:10];
      frame = '{8'hA5, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                8'h01, 8'h23, 8'h45, 8'h67};
      for (int i = 0; i < 11; i++) applyStimulus(frame[i], 0);
      applyStimulus(csumByte, 1);
   endtask

   // Linear sequence of directed scenarios.
   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      sData  = 8'h00;
      sValid = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rstReady",  {31'd0, sReady}, 32'd0);
      checkOutput("rstWe",     {31'd0, imemWe}, 32'd0);
      checkOutput("rstAddr",   {24'd0, imemAddr}, 32'd0);
      checkOutput("rstWdata",  imemWdata, 32'd0);
      checkOutput("rstCpuRst", {31'd0, cpuRst}, 32'd1);
      checkOutput("rstBusy",   {31'd0, busy}, 32'd0);
      checkOutput("rstDone",   {31'd0, done}, 32'd0);
      checkOutput("rstErr",    {31'd0, err}, 32'd0);
      rst = 1'b0;

      $display("[TB] two-word frame");
      pulseStart();
      checkOutput("startBusy",  {31'd0, busy}, 32'd1);
      checkOutput("startReady", {31'd0, sReady}, 32'd1);
      wrCount = 0;
      sendRefFrame(8'h22);
      checkOutput("f1Done",   {31'd0, done}, 32'd1);
      checkOutput("f1CpuRst", {31'd0, cpuRst}, 32'd0);
      checkOutput("f1Err",    {31'd0, err}, 32'd0);
      checkOutput("f1Ready",  {31'd0, sReady}, 32'd0);
      checkOutput("f1Writes", wrCount, 32'd2);
      checkOutput("f1Addr0",  {24'd0, wrAddr[0]}, 32'd0);
      checkOutput("f1Data0",  wrData[0], 32'hDEADBEEF);
      checkOutput("f1Addr1",  {24'd0, wrAddr[1]}, 32'd1);
      checkOutput("f1Data1",  wrData[1], 32'h01234567);

      $display("[TB] restart with leading garbage");
      pulseStart();
      checkOutput("reDone",   {31'd0, done}, 32'd0);
      checkOutput("reBusy",   {31'd0, busy}, 32'd1);
      checkOutput("reCpuRst", {31'd0, cpuRst}, 32'd1);
      wrCount = 0;
      applyStimulus(8'h00, 0);
      applyStimulus(8'hFF, 2);
      applyStimulus(8'h5A, 0);
      sendRefFrame(8'h22);
      checkOutput("f2Done",   {31'd0, done}, 32'd1);
      checkOutput("f2Writes", wrCount, 32'd2);
      checkOutput("f2Data0",  wrData[0], 32'hDEADBEEF);
      checkOutput("f2Addr1",  {24'd0, wrAddr[1]}, 32'd1);
      checkOutput("f2Data1",  wrData[1], 32'h01234567);

      $display("[TB] bad checksum on full frame");
      pulseStart();
      sendRefFrame(8'h62);
      checkOutput("badErr",    {31'd0, err}, 32'd1);
      checkOutput("badDone",   {31'd0, done}, 32'd0);
      checkOutput("badCpuRst", {31'd0, cpuRst}, 32'd1);

      $display("[TB] empty image");
      pulseStart();
      wrCount = 0;
      applyStimulus(8'hA5, 0);
      applyStimulus(8'h00, 0);
      applyStimulus(8'h00, 0);
      applyStimulus(8'h00, 0);
      checkOutput("n0Done",   {31'd0, done}, 32'd1);
      checkOutput("n0Writes", wrCount, 32'd0);
      pulseStart();
      applyStimulus(8'hA5, 0);
      applyStimulus(8'h00, 0);
      applyStimulus(8'h00, 0);
      applyStimulus(8'h01, 0);
      checkOutput("n0BadErr",    {31'd0, err}, 32'd1);
      checkOutput("n0BadCpuRst", {31'd0, cpuRst}, 32'd1);

      $display("[TB] oversize count");
      pulseStart();
      wrCount = 0;
      applyStimulus(8'hA5, 0);
      applyStimulus(8'h01, 0);
      applyStimulus(8'h01, 0);
      checkOutput("bigErr",   {31'd0, err}, 32'd1);
      checkOutput("bigReady", {31'd0, sReady}, 32'd0);
      checkOutput("bigBusy",  {31'd0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      checkOutput("bigWrites", wrCount, 32'd0);
      pulseStart();
      sendRefFrame(8'h22);
      checkOutput("bigRecover", {31'd0, done}, 32'd1);

      $display("[TB] full-depth image with random stalls");
      pulseStart();
      wrCount   = 0;
      csumModel = 8'h00;
      for (int i = 0; i < 1024; i++) begin
         payload[i] = 8'($urandom);
         csumModel  = csumModel ^ payload[i];
      end
      applyStimulus(8'hA5, 0);
      applyStimulus(8'h01, 0);
      applyStimulus(8'h00, 0);
      for (int i = 0; i < 1024; i++) applyStimulus(payload[i], int'($urandom_range(0, 2)));
      applyStimulus(csumModel, 0);
      checkOutput("fullDone",   {31'd0, done}, 32'd1);
      checkOutput("fullWrites", wrCount, 32'd256);
      for (int w = 0; w < 256; w++) begin
         checkOutput($sformatf("fullAddr%0d", w), {24'd0, wrAddr[w]}, w);
         checkOutput($sformatf("fullData%0d", w), wrData[w],
                     {payload[4*w], payload[4*w+1], payload[4*w+2], payload[4*w+3]});
      end

      $display("[TB] start ignored in load, then reset mid-session");
      pulseStart();
      wrCount = 0;
      applyStimulus(8'hA5, 0);
      applyStimulus(8'h00, 0);
      applyStimulus(8'h02, 0);
      applyStimulus(8'hDE, 0);
      applyStimulus(8'hAD, 0);
      pulseStart();
      checkOutput("loadBusy", {31'd0, busy}, 32'd1);
      applyStimulus(8'hBE, 0);
      applyStimulus(8'hEF, 0);
      applyStimulus(8'h01, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("midBusy",   {31'd0, busy}, 32'd0);
      checkOutput("midCpuRst", {31'd0, cpuRst}, 32'd1);
      checkOutput("midReady",  {31'd0, sReady}, 32'd0);
      checkOutput("midWe",     {31'd0, imemWe}, 32'd0);
      repeat (3) @(negedge clk);
      checkOutput("midWrites", wrCount, 32'd1);
      checkOutput("midData0",  wrData[0], 32'hDEADBEEF);
      checkOutput("midIdle",   {31'd0, busy}, 32'd0);

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
